// File: rtl/square_check.sv
// ----------------------------------------------------------------------------
// square_check
//
// Checks whether a candidate integer square root is exact. It squares the
// root with a sequential shift-add multiplier and then tests
// root*root <= x < (root+1)*(root+1).
//
// Ports
//   clk_in        sole clock, rising edge
//   rst_in        asynchronous, active-high reset
//   x             radicand under test (unsigned, WIDTH bits)
//   root          candidate floor(sqrt(x)) (unsigned, WIDTH bits)
//   valid_in      request strobe; operands captured when accepted in IDLE
//   square_out    root*root of the last completed request (2*WIDTH bits)
//   root_ok       root == floor(sqrt(x)) for the last completed request
//   result_valid  one-cycle pulse when square_out/root_ok are updated
//   busy          high while a request is in flight (state != IDLE)
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for valid_in; captures operands and clears acc/counter
// MULT  | one shift-add step per cycle over root bits 0..WIDTH-1
// CHECK | bound test on the finished square, publish result, back to IDLE
// ----------------------------------------------------------------------------
module square_check #(
    parameter int WIDTH = 19
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     root,
    input  logic                 valid_in,
    output logic [2*WIDTH-1:0]   square_out,
    output logic                 root_ok,
    output logic                 result_valid,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MULT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   x_q,     x_d;
    logic [WIDTH-1:0]   root_q,  root_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] sq_q,    sq_d;
    logic               ok_q,    ok_d;
    logic               rv_q,    rv_d;

    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH:0]   hi;
    logic [2*WIDTH:0]   acc_ext;
    logic [2*WIDTH:0]   x_ext;
    logic               check_ok;

    // root shifted into position for the current bit
    assign partial = {{WIDTH{1'b0}}, root_q} << cnt_q;

    // (root+1)^2 = root^2 + 2*root + 1; one extra bit so root = 2^WIDTH-1
    // does not wrap
    assign acc_ext  = {1'b0, acc_q};
    assign x_ext    = {{(WIDTH+1){1'b0}}, x_q};
    assign hi       = acc_ext + {{WIDTH{1'b0}}, root_q, 1'b0} + {{(2*WIDTH){1'b0}}, 1'b1};
    assign check_ok = (acc_ext <= x_ext) && (x_ext < hi);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        root_d  = root_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        ok_d    = ok_q;
        rv_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    x_d     = x;
                    root_d  = root;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                if (root_q[cnt_q]) begin
                    acc_d = acc_q + partial;
                end
                if (cnt_q == LAST_BIT) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CHECK: begin
                sq_d    = acc_q;
                ok_d    = check_ok;
                rv_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            root_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= '0;
            ok_q    <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            root_q  <= root_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            ok_q    <= ok_d;
            rv_q    <= rv_d;
        end
    end

    assign square_out   = sq_q;
    assign root_ok      = ok_q;
    assign result_valid = rv_q;
    assign busy         = (state_q != S_IDLE);

endmodule
